// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - opcode/aluop constants and the control bundle shared by the control pipe
package ctrl_pipe_pkg;

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_IALU   = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_CMP = 2'b01;
  localparam logic [1:0] ALUOP_RFN = 2'b10;
  localparam logic [1:0] ALUOP_IFN = 2'b11;

  typedef struct packed {
    logic [1:0] aluop;
    logic       imm_sel;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - ID-stage instruction fields in, stall/decode flags out
interface ctrl_pipe_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [6:0]        id_opcode;
  logic [2:0]        id_funct3;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_stall;
  logic              id_shift_imm_sel;
  logic              id_illegal;

  modport master (
    output id_valid, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
    input  id_stall, id_shift_imm_sel, id_illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
    output id_stall, id_shift_imm_sel, id_illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/funct3 to control bundle, illegal flag and source-use flags
module ctrl_decode import ctrl_pipe_pkg::*; #(
  parameter int REG_AW   = 5,
  parameter int HAS_JUMP = 1
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [REG_AW-1:0] rd,
  output ctrl_t             ctrl,
  output logic              illegal,
  output logic              shift_imm_sel,
  output logic              uses_rs1,
  output logic              uses_rs2
);

  always_comb begin
    ctrl          = CTRL_NOP;
    illegal       = 1'b0;
    shift_imm_sel = 1'b0;
    uses_rs1      = 1'b1;
    uses_rs2      = 1'b0;
    case (opcode)
      OPCODE_R: begin
        ctrl.aluop     = ALUOP_RFN;
        ctrl.reg_write = 1'b1;
        uses_rs2       = 1'b1;
      end
      OPCODE_IALU: begin
        ctrl.aluop     = ALUOP_IFN;
        ctrl.imm_sel   = 1'b1;
        ctrl.reg_write = 1'b1;
        shift_imm_sel  = (funct3 == 3'b001) || (funct3 == 3'b101);
      end
      OPCODE_LOAD: begin
        ctrl.imm_sel   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.memtoreg  = 1'b1;
      end
      OPCODE_STORE: begin
        ctrl.imm_sel   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rs2       = 1'b1;
      end
      OPCODE_BRANCH: begin
        ctrl.aluop  = ALUOP_CMP;
        ctrl.branch = 1'b1;
        uses_rs2    = 1'b1;
      end
      OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC: begin
        // Jump-class opcodes are only recognised when the core supports them.
        if (HAS_JUMP != 0) begin
          ctrl.reg_write = 1'b1;
          ctrl.jump      = (opcode == OPCODE_JAL) || (opcode == OPCODE_JALR);
          ctrl.imm_sel   = (opcode != OPCODE_JAL);
          uses_rs1       = (opcode == OPCODE_JALR);
        end else begin
          illegal  = 1'b1;
          uses_rs1 = 1'b0;
        end
      end
      default: begin
        illegal  = 1'b1;
        uses_rs1 = 1'b0;
      end
    endcase
    if (rd == '0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - decode plus ID/EX, EX/MEM, MEM/WB control registers, load-use stall,
// redirect flush and stall/flush event counters
module ctrl_pipe import ctrl_pipe_pkg::*; #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32,
  parameter int FLUSH_DEPTH = 2,
  parameter int HAS_JUMP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ctrl_pipe_if.slave        id_bus,
  input  logic              ex_redirect,
  output logic              ex_valid,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_alu_imm_sel,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit KILL_EX = (FLUSH_DEPTH >= 2);

  ctrl_t dec_ctrl;
  ctrl_t ex_ctrl;
  logic  dec_illegal;
  logic  dec_shift;
  logic  uses_rs1;
  logic  uses_rs2;
  logic  hazard;
  logic  id_take;
  logic  mem_reg_write;
  logic  mem_memtoreg;

  ctrl_decode #(
    .REG_AW   (REG_AW),
    .HAS_JUMP (HAS_JUMP)
  ) u_decode (
    .opcode        (id_bus.id_opcode),
    .funct3        (id_bus.id_funct3),
    .rd            (id_bus.id_rd),
    .ctrl          (dec_ctrl),
    .illegal       (dec_illegal),
    .shift_imm_sel (dec_shift),
    .uses_rs1      (uses_rs1),
    .uses_rs2      (uses_rs2)
  );

  assign hazard = id_bus.id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != '0) &
                  ((uses_rs1 & (ex_rd == id_bus.id_rs1)) |
                   (uses_rs2 & (ex_rd == id_bus.id_rs2)));

  // A redirect discards the ID slot, so there is nothing left to stall.
  assign id_bus.id_stall         = hazard & ~ex_redirect;
  assign id_bus.id_illegal       = id_bus.id_valid & dec_illegal;
  assign id_bus.id_shift_imm_sel = dec_shift;

  assign id_take = id_bus.id_valid & ~dec_illegal & ~hazard & ~ex_redirect;

  assign ex_branch      = ex_ctrl.branch;
  assign ex_jump        = ex_ctrl.jump;
  assign ex_alu_imm_sel = ex_ctrl.imm_sel;
  assign ex_aluop       = ex_ctrl.aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_ctrl       <= CTRL_NOP;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_memtoreg  <= 1'b0;
      mem_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_rd         <= '0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
    end else begin
      ex_valid <= id_take;
      ex_ctrl  <= id_take ? dec_ctrl : CTRL_NOP;
      ex_rd    <= id_take ? id_bus.id_rd : '0;

      if (KILL_EX && ex_redirect) begin
        mem_valid     <= 1'b0;
        mem_read      <= 1'b0;
        mem_write     <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_memtoreg  <= 1'b0;
        mem_rd        <= '0;
      end else begin
        mem_valid     <= ex_valid;
        mem_read      <= ex_ctrl.mem_read;
        mem_write     <= ex_ctrl.mem_write;
        mem_reg_write <= ex_ctrl.reg_write;
        mem_memtoreg  <= ex_ctrl.memtoreg;
        mem_rd        <= ex_rd;
      end

      wb_valid     <= mem_valid;
      wb_reg_write <= mem_reg_write;
      wb_memtoreg  <= mem_memtoreg;
      wb_rd        <= mem_rd;

      stall_cnt <= stall_cnt + CNT_W'(id_bus.id_stall);
      flush_cnt <= flush_cnt + CNT_W'(ex_redirect);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe against a slot-level pipeline model
module tb_ctrl_pipe;

  localparam int REG_AW      = 5;
  localparam int CNT_W       = 4;
  localparam int FLUSH_DEPTH = 2;
  localparam int HAS_JUMP    = 1;

  localparam bit [6:0] OP_R      = 7'b0110011;
  localparam bit [6:0] OP_IALU   = 7'b0010011;
  localparam bit [6:0] OP_LOAD   = 7'b0000011;
  localparam bit [6:0] OP_STORE  = 7'b0100011;
  localparam bit [6:0] OP_BRANCH = 7'b1100011;
  localparam bit [6:0] OP_JAL    = 7'b1101111;
  localparam bit [6:0] OP_JALR   = 7'b1100111;
  localparam bit [6:0] OP_LUI    = 7'b0110111;
  localparam bit [6:0] OP_AUIPC  = 7'b0010111;
  localparam bit [6:0] OP_BAD    = 7'b1111111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_redirect = 1'b0;
  logic              ex_valid, ex_branch, ex_jump, ex_alu_imm_sel;
  logic [1:0]        ex_aluop;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_valid, mem_read, mem_write;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_reg_write, wb_memtoreg;
  logic [REG_AW-1:0] wb_rd;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  ctrl_pipe_if #(.REG_AW(REG_AW)) bus ();

  ctrl_pipe #(
    .REG_AW(REG_AW), .CNT_W(CNT_W), .FLUSH_DEPTH(FLUSH_DEPTH), .HAS_JUMP(HAS_JUMP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_bus(bus), .ex_redirect(ex_redirect),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_alu_imm_sel(ex_alu_imm_sel), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit [6:0] op; bit [2:0] f3; bit [4:0] rd; } slot_t;
  typedef struct { bit stall; bit illegal; bit shift; } comb_t;
  typedef struct {
    bit ex_valid, ex_branch, ex_jump, ex_imm; bit [1:0] ex_aluop; bit [4:0] ex_rd;
    bit mem_valid, mem_read, mem_write; bit [4:0] mem_rd;
    bit wb_valid, wb_rw, wb_m2r; bit [4:0] wb_rd;
    int stall_cnt, flush_cnt;
  } snap_t;

  comb_t comb_q[$];
  snap_t seq_q[$];
  slot_t m_ex, m_mem, m_wb;
  int    m_stalls, m_flushes;
  int    checks = 0;
  int    errors = 0;
  bit [6:0] op_pool[12] = '{OP_R, OP_IALU, OP_LOAD, OP_LOAD, OP_STORE, OP_BRANCH,
                             OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BAD, 7'b0001111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit known(input bit [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  function automatic bit [1:0] aluop_of(input bit [6:0] op);
    if (op == OP_R) return 2'd2;
    if (op == OP_IALU) return 2'd3;
    if (op == OP_BRANCH) return 2'd1;
    return 2'd0;
  endfunction

  function automatic snap_t snap_of();
    snap_t s;
    s.ex_valid  = m_ex.v;
    s.ex_branch = m_ex.v && m_ex.op == OP_BRANCH;
    s.ex_jump   = m_ex.v && m_ex.op inside {OP_JAL, OP_JALR};
    s.ex_imm    = m_ex.v && m_ex.op inside {OP_IALU, OP_LOAD, OP_STORE, OP_JALR, OP_LUI, OP_AUIPC};
    s.ex_aluop  = m_ex.v ? aluop_of(m_ex.op) : 2'd0;
    s.ex_rd     = m_ex.v ? m_ex.rd : 5'd0;
    s.mem_valid = m_mem.v;
    s.mem_read  = m_mem.v && m_mem.op == OP_LOAD;
    s.mem_write = m_mem.v && m_mem.op == OP_STORE;
    s.mem_rd    = m_mem.v ? m_mem.rd : 5'd0;
    s.wb_valid  = m_wb.v;
    s.wb_rw     = m_wb.v && !(m_wb.op inside {OP_STORE, OP_BRANCH}) && m_wb.rd != 0;
    s.wb_m2r    = m_wb.v && m_wb.op == OP_LOAD;
    s.wb_rd     = m_wb.v ? m_wb.rd : 5'd0;
    s.stall_cnt = m_stalls;
    s.flush_cnt = m_flushes;
    return s;
  endfunction

  task automatic model_clear();
    m_ex = '{0, 7'd0, 3'd0, 5'd0};
    m_mem = m_ex;
    m_wb = m_ex;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  // One ID-slot cycle: drive, predict combinational flags and the post-edge state.
  task automatic step(input bit v, input bit [6:0] op, input bit [2:0] f3, input bit [4:0] rs1,
                      input bit [4:0] rs2, input bit [4:0] rd, input bit redir, output bit stalled);
    comb_t c;
    bit legal, u1, u2, hz;
    slot_t bub;
    @(negedge clk);
    bus.id_valid = v; bus.id_opcode = op; bus.id_funct3 = f3;
    bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd; ex_redirect = redir;
    bub = '{0, 7'd0, 3'd0, 5'd0};
    legal = known(op);
    u1 = legal && !(op inside {OP_JAL, OP_LUI, OP_AUIPC});
    u2 = op inside {OP_R, OP_STORE, OP_BRANCH};
    hz = v && m_ex.v && m_ex.op == OP_LOAD && m_ex.rd != 0 &&
         ((u1 && m_ex.rd == rs1) || (u2 && m_ex.rd == rs2));
    c.stall = hz && !redir;
    c.illegal = v && !legal;
    c.shift = (op == OP_IALU) && (f3 == 3'd1 || f3 == 3'd5);
    comb_q.push_back(c);
    m_wb = m_mem;
    m_mem = (redir && FLUSH_DEPTH >= 2) ? bub : m_ex;
    m_ex = (v && legal && !c.stall && !redir) ? '{1, op, f3, rd} : bub;
    m_stalls = (m_stalls + int'(c.stall)) % (1 << CNT_W);
    m_flushes = (m_flushes + int'(redir)) % (1 << CNT_W);
    seq_q.push_back(snap_of());
    stalled = c.stall;
  endtask

  task automatic issue(input bit [6:0] op, input bit [2:0] f3, input bit [4:0] rs1,
                       input bit [4:0] rs2, input bit [4:0] rd, input bit redir);
    bit st;
    step(1'b1, op, f3, rs1, rs2, rd, redir, st);
    for (int k = 0; k < 3 && st; k++) step(1'b1, op, f3, rs1, rs2, rd, 1'b0, st);
  endtask

  task automatic idle(input int n);
    bit st;
    for (int k = 0; k < n; k++) step(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, st);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_id_stall"}, bus.id_stall, 0);
    chk({tag, "_ex"}, {ex_valid, ex_branch, ex_jump, ex_alu_imm_sel, ex_aluop, ex_rd}, 0);
    chk({tag, "_mem"}, {mem_valid, mem_read, mem_write, mem_rd}, 0);
    chk({tag, "_wb"}, {wb_valid, wb_reg_write, wb_memtoreg, wb_rd}, 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_flush_cnt"}, flush_cnt, 0);
  endtask

  // Asserts reset between edges and checks that everything clears before the next edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.id_valid = 1'b0;
    ex_redirect = 1'b0;
    model_clear();
    #1;
    check_all_zero(tag);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    comb_t c;
    snap_t s;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("id_stall", bus.id_stall, c.stall);
        chk("id_illegal", bus.id_illegal, c.illegal);
        chk("id_shift_imm_sel", bus.id_shift_imm_sel, c.shift);
      end
      @(posedge clk);
      #1;
      if (seq_q.size() > 0) begin
        s = seq_q.pop_front();
        chk("ex_valid", ex_valid, s.ex_valid);
        chk("ex_branch", ex_branch, s.ex_branch);
        chk("ex_jump", ex_jump, s.ex_jump);
        chk("ex_alu_imm_sel", ex_alu_imm_sel, s.ex_imm);
        chk("ex_aluop", ex_aluop, s.ex_aluop);
        chk("ex_rd", ex_rd, s.ex_rd);
        chk("mem_valid", mem_valid, s.mem_valid);
        chk("mem_read", mem_read, s.mem_read);
        chk("mem_write", mem_write, s.mem_write);
        chk("mem_rd", mem_rd, s.mem_rd);
        chk("wb_valid", wb_valid, s.wb_valid);
        chk("wb_reg_write", wb_reg_write, s.wb_rw);
        chk("wb_memtoreg", wb_memtoreg, s.wb_m2r);
        chk("wb_rd", wb_rd, s.wb_rd);
        chk("stall_cnt", stall_cnt, s.stall_cnt);
        chk("flush_cnt", flush_cnt, s.flush_cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin : stimulus
    bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_funct3 = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    model_clear();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // load-use stall on rs1
    issue(OP_LOAD, 3'd2, 5'd1, 5'd0, 5'd5, 1'b0);
    issue(OP_R, 3'd0, 5'd5, 5'd7, 5'd6, 1'b0);
    chk("t1_stall_cnt", stall_cnt, 1);
    idle(3);
    apply_reset("t1_rst");

    // rd=0 load: no stall, no write-back
    issue(OP_LOAD, 3'd2, 5'd1, 5'd0, 5'd0, 1'b0);
    issue(OP_R, 3'd0, 5'd0, 5'd2, 5'd3, 1'b0);
    idle(3);
    chk("t2_stall_cnt", stall_cnt, 0);
    apply_reset("t2_rst");

    // redirect kills ID and EX
    issue(OP_BRANCH, 3'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(OP_R, 3'd0, 5'd3, 5'd4, 5'd4, 1'b1);
    idle(1);
    chk("t3_mem_valid", mem_valid, 0);
    chk("t3_flush_cnt", flush_cnt, 1);
    idle(2);
    apply_reset("t3_rst");

    // redirect beats a load-use hazard
    issue(OP_LOAD, 3'd2, 5'd1, 5'd0, 5'd9, 1'b0);
    issue(OP_R, 3'd0, 5'd9, 5'd2, 5'd3, 1'b1);
    idle(1);
    chk("t4_stall_cnt", stall_cnt, 0);
    chk("t4_flush_cnt", flush_cnt, 1);
    apply_reset("t4_rst");

    // shift immediate select and illegal opcode
    issue(OP_IALU, 3'd5, 5'd1, 5'd0, 5'd2, 1'b0);
    issue(OP_IALU, 3'd0, 5'd1, 5'd0, 5'd2, 1'b0);
    issue(OP_IALU, 3'd1, 5'd1, 5'd0, 5'd2, 1'b0);
    issue(OP_BAD, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    idle(4);
    apply_reset("t5_rst");

    // 17 hazards on a 4-bit counter wrap to 1, then reset with a full pipe
    for (int k = 0; k < 17; k++) begin
      issue(OP_LOAD, 3'd2, 5'd1, 5'd0, 5'd5, 1'b0);
      issue(OP_STORE, 3'd2, 5'd2, 5'd5, 5'd0, 1'b0);
    end
    chk("t6_stall_wrap", stall_cnt, 1);
    issue(OP_LOAD, 3'd2, 5'd1, 5'd0, 5'd7, 1'b0);
    issue(OP_JAL, 3'd0, 5'd7, 5'd7, 5'd1, 1'b0);
    issue(OP_R, 3'd0, 5'd2, 5'd3, 5'd4, 1'b0);
    apply_reset("t6_midrst");

    for (int n = 0; n < 400; n++) begin
      bit [6:0] op;
      bit st;
      op = op_pool[$urandom_range(0, 11)];
      step($urandom_range(0, 9) != 0, op, 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, st);
    end
    idle(4);
    @(negedge clk);
    @(negedge clk);
    chk("comb_q_drained", comb_q.size(), 0);
    chk("seq_q_drained", seq_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined main-control unit for the 5-stage RV32I core.
- Decodes the ID-stage instruction into a control bundle, then carries it through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall plus bubble) and applies taken-branch/jump flushes.
- Flags illegal opcodes and counts stall and flush events. Replaces the standalone combinational decoder.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, width of the stall and flush event counters
FLUSH_DEPTH, 2, number of younger slots killed on a redirect (1 = ID only, 2 = ID and EX)
HAS_JUMP, 1, decode JAL/JALR/LUI/AUIPC when 1; treat them as illegal when 0

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID slot holds a real instruction
id_opcode  in  7  instr[6:0]
id_funct3  in  3  instr[14:12]
id_rs1  in  REG_AW  source register 1
id_rs2  in  REG_AW  source register 2
id_rd  in  REG_AW  destination register
ex_redirect  in  1  branch taken or jump resolved in EX this cycle
id_stall  out  1  hold PC and IF/ID
id_shift_imm_sel  out  1  combinational; shamt immediate select
id_illegal  out  1  combinational; id_valid with an undecodable opcode
ex_valid, ex_branch, ex_jump, ex_alu_imm_sel  out  1  EX controls
ex_aluop  out  2  EX ALU op
ex_rd  out  REG_AW  EX destination register
mem_valid, mem_read, mem_write  out  1  MEM controls
mem_rd  out  REG_AW  MEM destination register
wb_valid, wb_reg_write, wb_memtoreg  out  1  WB controls
wb_rd  out  REG_AW  WB destination register
stall_cnt, flush_cnt  out  CNT_W  event counters

Behaviour:
- Reset: every registered output and both counters are 0. This is a bubble in every stage, and id_stall=0.
- Decode (combinational, ID stage):
  - R 0110011: aluop=10, reg_write=1.
  - I-ALU 0010011: aluop=11, imm_sel=1, reg_write=1. shift_imm_sel=1 iff funct3 is 001 or 101.
  - LOAD 0000011: aluop=00, imm_sel=1, mem_read=1, reg_write=1, memtoreg=1.
  - STORE 0100011: aluop=00, imm_sel=1, mem_write=1.
  - BRANCH 1100011: aluop=01, branch=1.
  - JAL 1101111 and JALR 1100111: jump=1, reg_write=1, aluop=00. JALR also has imm_sel=1.
  - LUI 0110111 and AUIPC 0010111: aluop=00, imm_sel=1, reg_write=1.
  - Any other opcode: all controls 0 and id_illegal=1.
  - reg_write is forced to 0 when rd==0.
- Load-use hazard, computed in the same cycle:
  - id_stall = id_valid & ex_valid & mem_read_in_EX & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - The rs2 match applies only to R, STORE and BRANCH; rs1 is unused by JAL, LUI and AUIPC.
  - On a stall the ID/EX register loads a bubble (all zero) and the ID instruction is re-presented next cycle.
  - Exactly one stall cycle per hazard.
- Redirect:
  - ex_redirect=1 at edge N kills the ID slot: ID/EX loads a bubble at that edge.
  - With FLUSH_DEPTH=2, the EX slot is also killed: EX/MEM loads a bubble instead of the EX bundle. Use this only when the branch resolves at the end of EX.
  - Redirect takes priority over stall in the same cycle: id_stall=0 and flush_cnt increments.
- Pipeline advance:
  - Each edge moves EX to MEM and MEM to WB unconditionally; there is no back-pressure from MEM in this generation.
  - Latency: ID decode to ex_* is 1 cycle, to mem_* is 2, to wb_* is 3.
- Counters:
  - stall_cnt increments on each cycle with id_stall=1.
  - flush_cnt increments on each cycle with ex_redirect=1.
  - Both wrap modulo 2^CNT_W without saturating.
- Illegal instructions enter the pipe as a bubble with ex_valid=0. Trap handling is outside this block.
- Reset asserted mid-operation clears all stages immediately (asynchronous); there is no drain.

Decomposition:
- Shared package/defines: opcode constants OPCODE_*, aluop encodings ALUOP_ADD/CMP/RFN/IFN, and the control-bundle field list.
- Sub-module ctrl_decode: pure combinational opcode/funct3 to bundle plus illegal flag, reusable by the future dual-issue variant.
- ctrl_pipe holds the pipeline registers, hazard logic and counters.

Test Plan:
1. LOAD rd=5, then ADD rs1=5 → id_stall=1 for exactly 1 cycle; EX shows a bubble; ADD reaches EX one cycle later; stall_cnt=1.
2. LOAD rd=0, then ADD rs1=0 → no stall; the load's wb_reg_write=0 three cycles after decode.
3. BRANCH in EX with ex_redirect=1 and FLUSH_DEPTH=2 → ID and EX slots become bubbles; mem_valid=0 next cycle; flush_cnt=1.
4. Redirect and load-use hazard in the same cycle → id_stall=0, flush_cnt increments, stall_cnt unchanged.
5. I-ALU with funct3=101 → id_shift_imm_sel=1; funct3=000 → 0. Opcode 1111111 → id_illegal=1, ex_valid=0 next cycle.
6. CNT_W=4 with 17 stalls → stall_cnt=1; assert rst_n=0 mid-stream → all outputs read 0 before the next clk edge.
